// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and constants for the round-robin mux arbiter.
// FSM encodings and requester source IDs.
package rr_mux_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } state_t;

    localparam logic SRC0 = 1'b0;
    localparam logic SRC1 = 1'b1;

endpackage

// File: rtl/rr_mux_arbiter_if.sv
// Requester and consumer valid/ready handshake bundle for rr_mux_arbiter.
// slave = arbiter view, master = requester/consumer environment view.
interface rr_mux_arbiter_if #(
    parameter int unsigned DATA_W = 8
);

    logic              req0_valid;
    logic [DATA_W-1:0] req0_data;
    logic              req0_last;
    logic              req0_ready;
    logic              req1_valid;
    logic [DATA_W-1:0] req1_data;
    logic              req1_last;
    logic              req1_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_src;
    logic              out_ready;

    modport slave (
        input  req0_valid, req0_data, req0_last,
        output req0_ready,
        input  req1_valid, req1_data, req1_last,
        output req1_ready,
        output out_valid, out_data, out_src,
        input  out_ready
    );

    modport master (
        output req0_valid, req0_data, req0_last,
        input  req0_ready,
        output req1_valid, req1_data, req1_last,
        input  req1_ready,
        input  out_valid, out_data, out_src,
        output out_ready
    );

endinterface

// File: rtl/mux2.sv
// Single-bit 2:1 mux: y = s ? b : a.
module mux2 (
    input  logic a,
    input  logic b,
    input  logic s,
    output logic y
);

    assign y = s ? b : a;

endmodule

// File: rtl/rr_mux_arbiter_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Two-requester round-robin arbiter driving a 2:1 data mux into a one-entry output slot.
// Optional burst locking is enabled with RR_MUX_ARBITER_BURST_LOCK_EN.
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    rr_mux_arbiter_if.slave   bus,
    output logic              sel,
    output logic [CNT_W-1:0]  gnt_cnt0,
    output logic [CNT_W-1:0]  gnt_cnt1
);

    state_t            state_q;
    state_t            state_d;
    logic              ptr;
    logic              space;
    logic              sel_valid;
    logic              sel_last;
    logic              acc;
    logic [DATA_W-1:0] mux_data;
    logic [DATA_W-1:0] out_data_q;
    logic              out_valid_q;
    logic              out_src_q;

    assign space = ~out_valid_q | bus.out_ready;

    always_comb begin
        sel = ptr;
        case (state_q)
            ST_LOCK0: sel = SRC0;
            ST_LOCK1: sel = SRC1;
            default: begin
                if (bus.req0_valid && !bus.req1_valid) begin
                    sel = SRC0;
                end else if (bus.req1_valid && !bus.req0_valid) begin
                    sel = SRC1;
                end
            end
        endcase
    end

    assign sel_valid      = sel ? bus.req1_valid : bus.req0_valid;
    assign acc            = space & sel_valid;
    assign bus.req0_ready = space & (sel == SRC0);
    assign bus.req1_ready = space & (sel == SRC1);

`ifdef RR_MUX_ARBITER_BURST_LOCK_EN
    assign sel_last = sel ? bus.req1_last : bus.req0_last;

    always_comb begin
        state_d = state_q;
        if (acc) begin
            state_d = sel_last ? ST_ARB : (sel ? ST_LOCK1 : ST_LOCK0);
        end
    end
`else
    // Every beat counts as a burst end, so the pointer advances on each grant.
    logic unused_last;
    assign unused_last = bus.req0_last ^ bus.req1_last;
    assign sel_last    = 1'b1;

    always_comb begin
        state_d = ST_ARB;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_ARB;
            ptr     <= SRC0;
        end else begin
            state_q <= state_d;
            if (acc && sel_last) begin
                ptr <= ~sel;
            end
        end
    end

    for (genvar i = 0; i < DATA_W; i++) begin : g_mux
        mux2 u_mux (
            .a (bus.req0_data[i]),
            .b (bus.req1_data[i]),
            .s (sel),
            .y (mux_data[i])
        );
    end

    // A same-cycle drain and accept simply overwrites the slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= SRC0;
        end else if (acc) begin
            out_valid_q <= 1'b1;
            out_data_q  <= mux_data;
            out_src_q   <= sel;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;

    sat_counter #(.CNT_W(CNT_W)) u_cnt0 (
        .clk (clk),
        .rst (rst),
        .inc (acc & (sel == SRC0)),
        .cnt (gnt_cnt0)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cnt1 (
        .clk (clk),
        .rst (rst),
        .inc (acc & (sel == SRC1)),
        .cnt (gnt_cnt1)
    );

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Scoreboard bench for rr_mux_arbiter: queue-based reference model plus negedge monitor.
// Honours RR_MUX_ARBITER_BURST_LOCK_EN in the same way as the design.
module tb_rr_mux_arbiter;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic       src;
        logic [7:0] data;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             sel;
    logic [CNT_W-1:0] gnt_cnt0;
    logic [CNT_W-1:0] gnt_cnt1;

    always #5 clk = ~clk;

    rr_mux_arbiter_if #(.DATA_W(DATA_W)) bus ();

    rr_mux_arbiter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .sel      (sel),
        .gnt_cnt0 (gnt_cnt0),
        .gnt_cnt1 (gnt_cnt1)
    );

    beat_t sb[$];
    beat_t seen[$];
    int    favoured;
    int    owner;
    int    cnt0_m;
    int    cnt1_m;
    int    total;
    int    bad;
    bit    checking;
    logic  exp_sel;
    logic  exp_r0;
    logic  exp_r1;
    logic  exp_full;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        seen.delete();
        favoured = 0;
        owner    = -1;
        cnt0_m   = 0;
        cnt1_m   = 0;
    endtask

    // One clock cycle: drive inputs, predict grant from the rules, advance at the edge.
    task automatic cycle(input bit v0, input logic [7:0] d0, input bit l0,
                         input bit v1, input logic [7:0] d1, input bit l1,
                         input bit rdy);
        int    g;
        bit    space;
        bit    take;
        bit    last;
        beat_t b;
        bus.req0_valid = v0;
        bus.req0_data  = d0;
        bus.req0_last  = l0;
        bus.req1_valid = v1;
        bus.req1_data  = d1;
        bus.req1_last  = l1;
        bus.out_ready  = rdy;
        if (owner >= 0)        g = owner;
        else if (v0 && !v1)    g = 0;
        else if (v1 && !v0)    g = 1;
        else                   g = favoured;
        exp_full = (sb.size() > 0);
        space    = !exp_full || rdy;
        exp_sel  = (g == 1);
        exp_r0   = space && (g == 0);
        exp_r1   = space && (g == 1);
        take     = space && ((g == 0) ? v0 : v1);
        if (take) begin
            b.src  = (g == 1);
            b.data = (g == 0) ? d0 : d1;
            sb.push_back(b);
        end
        checking = 1'b1;
        @(posedge clk);
        #1;
        if (take) begin
            last = (g == 0) ? l0 : l1;
            if (g == 0 && cnt0_m < CNT_MAX) cnt0_m++;
            if (g == 1 && cnt1_m < CNT_MAX) cnt1_m++;
`ifdef RR_MUX_ARBITER_BURST_LOCK_EN
            if (last) begin
                owner    = -1;
                favoured = 1 - g;
            end else begin
                owner = g;
            end
`else
            last     = 1'b1;
            favoured = 1 - g;
`endif
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
    endtask

    // Asynchronous reset between clock edges; outputs must clear before any edge.
    task automatic reset_pulse();
        #1;
        checking = 1'b0;
        rst      = 1'b1;
        #1;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_data",  bus.out_data,  8'h00);
        chk("rst_out_src",   bus.out_src,   1'b0);
        chk("rst_cnt0",      gnt_cnt0,      '0);
        chk("rst_cnt1",      gnt_cnt1,      '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic chk_seen(input int idx, input logic src, input logic [7:0] data);
        if (idx < seen.size()) begin
            chk("seen_src",  seen[idx].src,  src);
            chk("seen_data", seen[idx].data, data);
        end else begin
            chk("seen_len", seen.size(), idx + 1);
        end
    endtask

    always @(negedge clk) begin
        beat_t b;
        if (checking && !rst) begin
            chk("sel",        sel,            exp_sel);
            chk("req0_ready", bus.req0_ready, exp_r0);
            chk("req1_ready", bus.req1_ready, exp_r1);
            chk("out_valid",  bus.out_valid,  exp_full);
            if (exp_full && sb.size() > 0) begin
                chk("out_data", bus.out_data, sb[0].data);
                chk("out_src",  bus.out_src,  sb[0].src);
                if (bus.out_ready) begin
                    b.src  = bus.out_src;
                    b.data = bus.out_data;
                    seen.push_back(b);
                    void'(sb.pop_front());
                end
            end
            chk("gnt_cnt0", gnt_cnt0, cnt0_m);
            chk("gnt_cnt1", gnt_cnt1, cnt1_m);
        end
    end

    initial begin
        logic [7:0] r0;
        logic [7:0] r1;
        total    = 0;
        bad      = 0;
        checking = 1'b0;
        model_reset();
        bus.req0_valid = 1'b0;
        bus.req0_data  = '0;
        bus.req0_last  = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req1_data  = '0;
        bus.req1_last  = 1'b0;
        bus.out_ready  = 1'b0;

        #12;
        chk("init_out_valid", bus.out_valid, 1'b0);
        chk("init_out_data",  bus.out_data,  8'h00);
        chk("init_cnt0",      gnt_cnt0,      '0);
        chk("init_cnt1",      gnt_cnt1,      '0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Alternation with both requesters always valid.
        for (int i = 0; i < 6; i++) cycle(1'b1, 8'hA0, 1'b1, 1'b1, 8'hB1, 1'b1, 1'b1);
        idle(1);
        for (int i = 0; i < 6; i++) chk_seen(i, (i % 2) == 1, ((i % 2) == 1) ? 8'hB1 : 8'hA0);
        chk("alt_cnt0", gnt_cnt0, 3);
        chk("alt_cnt1", gnt_cnt1, 3);

        // Backpressure holding a src-1 beat.
        seen.delete();
        cycle(1'b0, 8'h00, 1'b1, 1'b1, 8'h55, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'h11, 1'b1, 1'b1, 8'h22, 1'b1, 1'b0);
        cycle(1'b1, 8'h11, 1'b1, 1'b1, 8'h22, 1'b1, 1'b1);
        idle(1);
        chk_seen(0, 1'b1, 8'h55);
        chk_seen(1, 1'b0, 8'h11);

        // Reset while a beat is stalled in the slot.
        cycle(1'b1, 8'h77, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("pre_rst_valid", bus.out_valid, 1'b1);
        reset_pulse();
        cycle(1'b1, 8'h31, 1'b1, 1'b1, 8'h32, 1'b1, 1'b1);
        idle(1);
        chk_seen(0, 1'b0, 8'h31);

        // Single requester.
        reset_pulse();
        for (int i = 0; i < 5; i++) cycle(1'b0, 8'hEE, 1'b1, 1'b1, 8'(8'h40 + i), 1'b1, 1'b1);
        idle(1);
        for (int i = 0; i < 5; i++) chk_seen(i, 1'b1, 8'(8'h40 + i));
        chk("single_cnt1", gnt_cnt1, 5);
        chk("single_cnt0", gnt_cnt0, 0);

        // Counter saturation.
        reset_pulse();
        for (int i = 0; i < 20; i++) cycle(1'b1, 8'(i), 1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
        idle(1);
        chk("sat_cnt0", gnt_cnt0, 15);

        // Three-beat burst from requester 0 competing with requester 1.
        reset_pulse();
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 8'(8'h10 + i), (i == 2), 1'b1, 8'(8'h20 + i), 1'b1, 1'b1);
        idle(1);
`ifdef RR_MUX_ARBITER_BURST_LOCK_EN
        chk_seen(0, 1'b0, 8'h10);
        chk_seen(1, 1'b0, 8'h11);
        chk_seen(2, 1'b0, 8'h12);
        chk_seen(3, 1'b1, 8'h23);
`else
        chk_seen(0, 1'b0, 8'h10);
        chk_seen(1, 1'b1, 8'h21);
        chk_seen(2, 1'b0, 8'h12);
        chk_seen(3, 1'b1, 8'h23);
`endif

        // Randomised traffic with random bursts and backpressure.
        reset_pulse();
        for (int i = 0; i < 800; i++) begin
            r0 = 8'($urandom_range(0, 255));
            r1 = 8'($urandom_range(0, 255));
            cycle($urandom_range(0, 3) != 0, r0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 3) != 0, r1, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 3) != 0);
        end
        idle(2);
        checking = 1'b0;
        chk("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
